// File: rtl/pio_pkg.sv
// Shared constants for the input PIO: register map and edge-select encodings.
package pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain followed by an optional stability filter.
module pio_debounce_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic din_i,
   output logic stable_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
   end

   assign synced = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign stable_o = synced;
      end else begin : g_db
         localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
         localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] cnt_q, cnt_d;
         logic          stable_q, stable_d;

         // A binary input that changes away from stable was matching the cycle
         // before, so the counter is already zero; only mismatch cycles count.
         always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (synced != stable_q) begin
               if (cnt_q == CNT_LAST) stable_d = synced;
               else                   cnt_d    = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               cnt_q    <= '0;
               stable_q <= 1'b0;
            end else begin
               cnt_q    <= cnt_d;
               stable_q <= stable_d;
            end
         end

         assign stable_o = stable_q;
      end
   endgenerate

endmodule

// File: rtl/pio_input_irq.sv
// Avalon-MM input PIO: per-bit sync/debounce, edge capture (W1C), masked level irq.
module pio_input_irq
   import pio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] edge_det;
   logic [31:0]      readdata_q, readdata_d;
   logic             wr_en;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk_i   (clk),
         .rst_ni  (reset_n),
         .din_i   (in_port[i]),
         .stable_o(stable[i])
      );
   end

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      case (EDGE_TYPE)
         EDGE_FALL: edge_det = ~stable & prev_q;
         EDGE_ANY:  edge_det = stable ^ prev_q;
         default:   edge_det = stable & ~prev_q;
      endcase
   end

   // Clear is applied before the new edge is ORed in so a coincident edge survives.
   always_comb begin
      mask_d = mask_q;
      cap_d  = cap_q;
      if (wr_en && address == ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
      if (wr_en && address == ADDR_EDGECAP) cap_d = cap_q & ~writedata[WIDTH-1:0];
      cap_d = cap_d | edge_det;
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
         ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
         ADDR_EDGECAP: readdata_d[WIDTH-1:0] = cap_q;
         default:      readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_q     <= '0;
         mask_q     <= '0;
         cap_q      <= '0;
         readdata_q <= '0;
      end else begin
         prev_q     <= stable;
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_input_irq.sv
// Directed bench for pio_input_irq: three configurations on a shared bus, read scoreboard.
module tb_pio_input_irq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] rd0, rd1, rd2;
   logic        irq0, irq1, irq2;
   logic [7:0]  in0, in1;
   logic [31:0] in2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      int          d;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   pio_input_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));

   pio_input_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));

   pio_input_irq #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] e);
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic e);
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s: got %b expected %b", tag, obs, e);
      end
   endtask

   // Read with chipselect low: the read mux must not depend on it.
   task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string tag);
      exp_t x;
      @(negedge clk);
      address    = a;
      chipselect = 1'b0;
      write_n    = 1'b1;
      sb.push_back('{tag, d, e});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      case (x.d)
         0:       check32(x.tag, rd0, x.exp);
         1:       check32(x.tag, rd1, x.exp);
         default: check32(x.tag, rd2, x.exp);
      endcase
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] dat);
      @(negedge clk);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = dat;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      in0 = 8'hFF; in1 = 8'h00; in2 = 32'h0;

      // Reset with inputs high
      repeat (3) @(posedge clk);
      #1;
      check32("reset_readdata", rd0, 32'h0);
      check1("reset_irq", irq0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      rd(0, 2'd0, 32'h0000_00FF, "post_reset_data");
      rd(0, 2'd3, 32'h0000_00FF, "post_reset_edgecap");
      check1("post_reset_irq_masked", irq0, 1'b0);

      // Read path
      in0 = 8'hA5;
      idle(4);
      rd(0, 2'd0, 32'h0000_00A5, "data_a5");
      rd(0, 2'd1, 32'h0, "rsvd_zero");

      // Edge capture and irq
      in0 = 8'hA4;
      idle(4);
      wr(2'd3, 32'hFF);
      rd(0, 2'd3, 32'h0, "edgecap_cleared");
      wr(2'd2, 32'h01);
      rd(0, 2'd2, 32'h01, "irqmask_rb");
      in0 = 8'hA5;
      idle(4);
      rd(0, 2'd3, 32'h01, "edgecap_bit0");
      check1("irq_set", irq0, 1'b1);
      wr(2'd3, 32'h01);
      check1("irq_cleared", irq0, 1'b0);
      in0 = 8'hA4;
      idle(4);
      rd(0, 2'd3, 32'h0, "fall_ignored");
      check1("irq_after_fall", irq0, 1'b0);

      // Edge lands on the W1C cycle: input change before edge 1, cap sets at edge 3
      @(negedge clk);
      in0 = 8'hAC;
      @(posedge clk);
      @(posedge clk);
      wr(2'd3, 32'h08);
      rd(0, 2'd3, 32'h08, "set_beats_clear");
      check1("irq_bit3_unmasked", irq0, 1'b0);

      // Debounce: 3-cycle glitch rejected
      @(negedge clk);
      in1 = 8'h02;
      idle(3);
      in1 = 8'h00;
      idle(10);
      rd(1, 2'd0, 32'h0, "glitch_data");
      rd(1, 2'd3, 32'h0, "glitch_edgecap");
      // 5-cycle pulse accepted
      @(negedge clk);
      in1 = 8'h02;
      idle(5);
      in1 = 8'h00;
      rd(1, 2'd0, 32'h02, "pulse_data");
      idle(10);
      rd(1, 2'd3, 32'h02, "pulse_edgecap");
      rd(1, 2'd0, 32'h0, "pulse_data_released");

      // 32-bit, any-edge configuration
      wr(2'd3, 32'hFFFF_FFFF);
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2, 2'd2, 32'hFFFF_FFFF, "mask32_rb");
      rd(0, 2'd2, 32'h0000_00FF, "mask8_upper_zero");
      rd(2, 2'd3, 32'h0, "cap32_clear");
      in2 = 32'h8000_0000;
      idle(4);
      rd(2, 2'd3, 32'h8000_0000, "bit31_rise");
      check1("irq32_set", irq2, 1'b1);
      wr(2'd3, 32'h8000_0000);
      rd(2, 2'd3, 32'h0, "bit31_cleared");
      in2 = 32'h0;
      idle(4);
      rd(2, 2'd3, 32'h8000_0000, "bit31_fall");

      // Reset with irq pending
      check1("irq32_pending", irq2, 1'b1);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check1("irq32_reset", irq2, 1'b0);
      check32("readdata32_reset", rd2, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(2, 2'd2, 32'h0, "mask32_after_reset");
      rd(2, 2'd3, 32'h0, "cap32_after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL timeout: total=%0d bad=%0d", total, bad);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
